// File: rtl/vga_pmod_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pmod_decoder
//  Description : Receive side of the TinyVGA PMOD. Locks onto the hsync/vsync
//                timing, recovers pixel coordinates and colour, signs each
//                clean frame with a 16-bit MISR and counts timing errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pmod_decoder #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_pmod,
    output logic [9:0]  o_hpos,
    output logic [9:0]  o_vpos,
    output logic [5:0]  o_pixel,
    output logic        o_active,
    output logic        o_locked,
    output logic        o_frame_done,
    output logic [15:0] o_signature,
    output logic [7:0]  o_err_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  H_ACT_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] WD_LAST    = 11'(2 * H_TOTAL - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        HLOCK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  p_r;
    logic        hs_prev;
    logic        vs_line;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [10:0] wd_cnt;
    logic        dirty;
    logic [15:0] sig;

    logic        hs_fall, hs_rise, vs_fall, vs_rise;
    logic        tracking, h_err, v_err, any_err, wd_expire;
    logic [9:0]  h_now, v_now, h_next, v_next;
    logic        active_now, first_px, last_px, publish;
    logic [5:0]  pixel_now;
    logic [15:0] sig_base, sig_next;

    // Edge detection, counter realignment, error decode and MISR step for the sample in p_r
    always_comb begin
        hs_fall  = hs_prev & ~p_r[7];
        hs_rise  = ~hs_prev & p_r[7];
        // Vsync is only looked at once per line, on column 0 of the free-running counter
        vs_fall  = (h_cnt == '0) & vs_line & ~p_r[3];
        vs_rise  = (h_cnt == '0) & ~vs_line & p_r[3];
        tracking = (state != SEARCH);
        h_err    = tracking & ((hs_fall & (h_cnt != HS_START)) | (hs_rise & (h_cnt != HS_END)));
        v_err    = (state == LOCKED) & ((vs_fall & (v_cnt != VS_START)) | (vs_rise & (v_cnt != VS_END)));
        any_err  = h_err | v_err;

        // A sync edge defines where we are; in a healthy stream these equal the counters
        h_now = h_cnt;
        if (hs_fall)
            h_now = HS_START;
        else if (hs_rise && tracking)
            h_now = HS_END;

        v_now = v_cnt;
        if (vs_fall && tracking)
            v_now = VS_START;
        else if (vs_rise && (state == LOCKED))
            v_now = VS_END;

        h_next = (h_now == H_LAST) ? '0 : h_now + 10'd1;
        v_next = v_now;
        if (h_now == H_LAST)
            v_next = (v_now == V_LAST) ? '0 : v_now + 10'd1;

        wd_expire = tracking & ~hs_fall & (wd_cnt == WD_LAST);

        state_next = state;
        case (state)
            SEARCH:  if (hs_fall) state_next = HLOCK;
            HLOCK:   if (vs_fall && !h_err) state_next = LOCKED;
            LOCKED:  if (any_err) state_next = HLOCK;
            default: state_next = SEARCH;
        endcase
        if (wd_expire)
            state_next = SEARCH;

        pixel_now  = {p_r[0], p_r[4], p_r[1], p_r[5], p_r[2], p_r[6]};
        active_now = (state == LOCKED) & (h_now < H_ACT) & (v_now < V_ACT);
        first_px   = active_now & (h_now == '0) & (v_now == '0);
        last_px    = active_now & (h_now == H_ACT_LAST) & (v_now == V_ACT_LAST);

        // The first pixel of a frame restarts the MISR from zero and folds itself in
        sig_base = first_px ? '0 : sig;
        sig_next = {sig_base[14:0], 1'b0} ^ (sig_base[15] ? 16'h1021 : 16'h0000)
                 ^ {10'b0, pixel_now};
        publish  = last_px & ~dirty & ~any_err;
    end

    // Input sampling stage: every downstream decision is made on p_r
    always_ff @(posedge clk) begin
        if (!rst_n)
            p_r <= 8'hFF;
        else
            p_r <= i_pmod;
    end

    // Sync tracking state machine with its counters, watchdog and frame signature
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= SEARCH;
            hs_prev <= 1'b1;
            vs_line <= 1'b1;
            h_cnt   <= '0;
            v_cnt   <= '0;
            wd_cnt  <= '0;
            dirty   <= 1'b1;
            sig     <= '0;
        end else begin
            state   <= state_next;
            hs_prev <= p_r[7];
            // While searching, follow vsync continuously so a lock acquired mid-pulse sees no false edge
            if (state == SEARCH || h_cnt == '0)
                vs_line <= p_r[3];
            h_cnt <= h_next;
            v_cnt <= v_next;
            if (hs_fall)
                wd_cnt <= '0;
            else if (wd_cnt != WD_LAST)
                wd_cnt <= wd_cnt + 11'd1;
            // A frame only stays clean if its first pixel was seen locked and no error followed
            if (any_err || state != LOCKED)
                dirty <= 1'b1;
            else if (first_px)
                dirty <= 1'b0;
            if (active_now)
                sig <= sig_next;
        end
    end

    // Output stage: coordinates, colour and status aligned to the same sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_hpos       <= '0;
            o_vpos       <= '0;
            o_pixel      <= '0;
            o_active     <= 1'b0;
            o_locked     <= 1'b0;
            o_frame_done <= 1'b0;
            o_signature  <= '0;
            o_err_count  <= '0;
        end else begin
            o_hpos       <= h_now;
            o_vpos       <= v_now;
            o_pixel      <= pixel_now;
            o_active     <= active_now;
            o_locked     <= (state == LOCKED);
            o_frame_done <= publish;
            if (publish)
                o_signature <= sig_next;
            if (any_err && o_err_count != 8'hFF)
                o_err_count <= o_err_count + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_pmod_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_pmod_decoder
//  Description : Directed bench for vga_pmod_decoder on a scaled-down raster
//                (32 x 19 total, 16 x 12 active) so whole frames stay short.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pmod_decoder;

    localparam int HA = 16, HFP = 4, HSY = 8, HBP = 4;
    localparam int VA = 12, VFP = 2, VSY = 2, VBP = 3;
    localparam int HT = HA + HFP + HSY + HBP;     // 32
    localparam int VT = VA + VFP + VSY + VBP;     // 19
    localparam int HSS = HA + HFP;                // 20
    localparam int HSE = HSS + HSY;               // 28
    localparam int VSS = VA + VFP;                // 14
    localparam int VSE = VSS + VSY;               // 16
    localparam int LIMIT = 20000;

    logic        clk;
    logic        rst_n;
    logic [7:0]  i_pmod;
    logic [9:0]  o_hpos, o_vpos;
    logic [5:0]  o_pixel;
    logic        o_active, o_locked, o_frame_done;
    logic [15:0] o_signature;
    logic [7:0]  o_err_count;

    vga_pmod_decoder #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_pmod      (i_pmod),
        .o_hpos      (o_hpos),
        .o_vpos      (o_vpos),
        .o_pixel     (o_pixel),
        .o_active    (o_active),
        .o_locked    (o_locked),
        .o_frame_done(o_frame_done),
        .o_signature (o_signature),
        .o_err_count (o_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          fd_cnt   = 0;
    logic [15:0] last_sig = 16'h0;

    // Stream generator state: position of the next pixel to send
    int          hcur = 0, vcur = 0;
    int          sp_h = 0, sp_v = 0;
    logic [5:0]  sp_px = 6'h00;
    logic        hold_hs = 1'b0;
    int          slip_line = 0, slip_left = 0;

    // Frame-done monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n && o_frame_done) begin
            fd_cnt   = fd_cnt + 1;
            last_sig = o_signature;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Send one pixel of the raster and advance; a slip drops three front-porch pixels
    task automatic step();
        logic       hs, vs;
        logic [5:0] px;
        hs = hold_hs ? 1'b1 : !((hcur >= HSS) && (hcur < HSE));
        vs = !((vcur >= VSS) && (vcur < VSE));
        px = (hcur < HA && vcur < VA && hcur == sp_h && vcur == sp_v) ? sp_px : 6'h00;
        i_pmod = {hs, px[0], px[2], px[4], vs, px[1], px[3], px[5]};
        @(posedge clk);
        #1;
        if (hcur == HSS - 4 && slip_left > 0 && vcur >= slip_line) begin
            hcur      = HSS;
            slip_left = slip_left - 1;
        end else if (hcur == HT - 1) begin
            hcur = 0;
            vcur = (vcur == VT - 1) ? 0 : vcur + 1;
        end else begin
            hcur = hcur + 1;
        end
    endtask

    task automatic run_to(input int v, input int h);
        int n;
        n = 0;
        do begin
            step();
            n = n + 1;
        end while (!(vcur == v && hcur == h) && n < LIMIT);
        if (n >= LIMIT) begin
            failures = failures + 1;
            $error("FAIL run_to_timeout observed=%0d expected=%0d", n, LIMIT);
        end
    endtask

    task automatic run_slips(input int count);
        int n;
        int nxt;
        n = 0;
        slip_line = 0;
        slip_left = count;
        while (slip_left > 0 && n < LIMIT) begin
            step();
            n = n + 1;
        end
        if (n >= LIMIT) begin
            failures = failures + 1;
            $error("FAIL slip_timeout observed=%0d expected=%0d", n, LIMIT);
        end
        nxt = (vcur == VT - 1) ? 0 : vcur + 1;
        run_to(nxt, 0);
    endtask

    initial begin
        int base;
        rst_n  = 1'b0;
        i_pmod = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hpos", o_hpos, 0);
        chk("rst_vpos", o_vpos, 0);
        chk("rst_pixel", o_pixel, 0);
        chk("rst_active", o_active, 0);
        chk("rst_locked", o_locked, 0);
        chk("rst_frame_done", o_frame_done, 0);
        chk("rst_signature", o_signature, 0);
        chk("rst_err", o_err_count, 0);
        rst_n = 1'b1;

        // Frame 0: acquire h, then lock on the first vsync line
        run_to(VSS, 0);
        chk("lock_before_vs", o_locked, 0);
        run_to(VSS, 3);
        chk("lock_at_vs", o_locked, 1);
        chk("vpos_at_vs", o_vpos, VSS);
        run_to(0, 0);
        chk("fd_frame0", fd_cnt, 0);

        // Frames 1, 2: clean black frames
        run_to(0, 0);
        chk("fd_frame1", fd_cnt, 1);
        chk("sig_frame1", o_signature, 16'h0000);
        run_to(0, 0);
        chk("fd_frame2", fd_cnt, 2);
        chk("sig_frame2", o_signature, 16'h0000);
        chk("err_clean", o_err_count, 0);

        // Frame 3: single pixel 01 on the last active pixel
        sp_h = HA - 1; sp_v = VA - 1; sp_px = 6'h01;
        run_to(0, 0);
        chk("fd_frame3", fd_cnt, 3);
        chk("sig_last_px", o_signature, 16'h0001);
        chk("sig_last_px_mon", last_sig, 16'h0001);

        // Frame 4: same pixel one column earlier
        sp_h = HA - 2;
        run_to(0, 0);
        chk("fd_frame4", fd_cnt, 4);
        chk("sig_second_last", o_signature, 16'h0002);

        // Frame 5: output alignment at (0,0) and first blank column
        sp_h = 0; sp_v = 0; sp_px = 6'h2A;
        run_to(0, 2);
        chk("align_hpos", o_hpos, 0);
        chk("align_vpos", o_vpos, 0);
        chk("align_pixel", o_pixel, 6'h2A);
        chk("align_active", o_active, 1);
        run_to(0, HA + 2);
        chk("blank_hpos", o_hpos, HA);
        chk("blank_active", o_active, 0);
        run_to(0, 0);
        chk("fd_frame5", fd_cnt, 5);

        // Frame 6: one 3-pixel timing slip on line 3
        sp_px = 6'h00;
        slip_line = 3; slip_left = 1;
        run_to(5, 0);
        chk("slip_err", o_err_count, 1);
        chk("slip_unlocked", o_locked, 0);
        run_to(VSS, 0);
        chk("slip_still_unlocked", o_locked, 0);
        run_to(VSS, 3);
        chk("slip_relock", o_locked, 1);
        run_to(0, 0);
        chk("fd_slip_frame", fd_cnt, 5);

        // Frame 7: clean again
        run_to(0, 0);
        chk("fd_after_slip", fd_cnt, 6);
        chk("sig_after_slip", o_signature, 16'h0000);

        // Frame 8: hsync held high for three lines trips the watchdog
        run_to(2, 0);
        hold_hs = 1'b1;
        run_to(5, 0);
        hold_hs = 1'b0;
        chk("wd_unlocked", o_locked, 0);
        chk("wd_err_unchanged", o_err_count, 1);
        run_to(VSS, 3);
        chk("wd_relock", o_locked, 1);
        chk("wd_err_after", o_err_count, 1);
        run_to(0, 0);
        chk("fd_wd_frame", fd_cnt, 6);

        // 300 slipped lines: 253 then 47 more
        run_slips(253);
        chk("err_254", o_err_count, 254);
        run_slips(47);
        chk("err_sat", o_err_count, 255);

        // Relock and sign one clean frame
        run_to(VSS + 1, 0);
        run_to(0, 0);
        base = fd_cnt;
        sp_h = HA - 1; sp_v = VA - 1; sp_px = 6'h01;
        run_to(0, 0);
        chk("fd_after_sat", fd_cnt, base + 1);
        chk("sig_after_sat", o_signature, 16'h0001);

        // Mid-frame reset for one clock
        sp_px = 6'h00;
        run_to(5, 7);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_hpos", o_hpos, 0);
        chk("mid_rst_vpos", o_vpos, 0);
        chk("mid_rst_active", o_active, 0);
        chk("mid_rst_locked", o_locked, 0);
        chk("mid_rst_frame_done", o_frame_done, 0);
        chk("mid_rst_signature", o_signature, 0);
        chk("mid_rst_err", o_err_count, 0);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
